// File: rtl/scr1_tcm_portb_arb.sv
// Port B arbiter for the TCM: shares one read/write port between the core data
// path and the boot/debug loader, with bounded loader bursts and a boot override.
module scr1_tcm_portb_arb #(
  parameter int SCR1_WIDTH = 32,
  parameter int SCR1_SIZE  = 32'h00010000,
  parameter int AW         = $clog2(SCR1_SIZE) - 2,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  boot_mode,

  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [3:0]            core_be,
  input  logic [AW-1:0]         core_addr,
  input  logic [SCR1_WIDTH-1:0] core_wdata,
  output logic                  core_ack,
  output logic                  core_rvalid,
  output logic [SCR1_WIDTH-1:0] core_rdata,

  input  logic                  ldr_req,
  input  logic                  ldr_we,
  input  logic [3:0]            ldr_be,
  input  logic [AW-1:0]         ldr_addr,
  input  logic [SCR1_WIDTH-1:0] ldr_wdata,
  output logic                  ldr_ack,
  output logic                  ldr_rvalid,
  output logic [SCR1_WIDTH-1:0] ldr_rdata,

  output logic                  renb,
  output logic                  wenb,
  output logic [3:0]            webb,
  output logic [AW-1:0]         addrb,
  output logic [SCR1_WIDTH-1:0] datab,
  input  logic [SCR1_WIDTH-1:0] qb
);

  localparam logic [3:0] LP_MAX_BURST = 4'(MAX_BURST);

  logic [3:0]            r_burst_cnt;
  logic                  r_rsp_v;
  logic                  r_rsp_id;
  logic [AW-1:0]         r_addrb;
  logic [SCR1_WIDTH-1:0] r_datab;

  logic                  w_burst_open;
  logic                  w_gnt_core;
  logic                  w_gnt_ldr;
  logic                  w_gnt;
  logic                  w_we;
  logic [3:0]            w_be;
  logic [AW-1:0]         w_addr;
  logic [SCR1_WIDTH-1:0] w_wdata;

  // rst_n gates the grant so nothing is acked or issued while reset is held
  assign w_burst_open = (r_burst_cnt < LP_MAX_BURST);
  assign w_gnt_ldr    = rst_n & ldr_req & (boot_mode | ~core_req | w_burst_open);
  assign w_gnt_core   = rst_n & ~boot_mode & core_req & (~ldr_req | ~w_burst_open);
  assign w_gnt        = w_gnt_ldr | w_gnt_core;

  assign w_we    = w_gnt_ldr ? ldr_we    : core_we;
  assign w_be    = w_gnt_ldr ? ldr_be    : core_be;
  assign w_addr  = w_gnt_ldr ? ldr_addr  : core_addr;
  assign w_wdata = w_gnt_ldr ? ldr_wdata : core_wdata;

  assign core_ack = w_gnt_core;
  assign ldr_ack  = w_gnt_ldr;

  assign renb  = w_gnt & ~w_we;
  assign wenb  = w_gnt & w_we;
  assign webb  = (w_gnt & w_we) ? w_be : 4'h0;
  assign addrb = w_gnt ? w_addr  : r_addrb;
  assign datab = w_gnt ? w_wdata : r_datab;

  assign core_rvalid = r_rsp_v & ~r_rsp_id;
  assign ldr_rvalid  = r_rsp_v & r_rsp_id;
  assign core_rdata  = qb;
  assign ldr_rdata   = qb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_burst_cnt <= 4'h0;
      r_rsp_v     <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_addrb     <= '0;
      r_datab     <= '0;
    end else begin
      if (w_gnt) begin
        r_addrb <= w_addr;
        r_datab <= w_wdata;
      end
      r_rsp_v  <= w_gnt & ~w_we;
      r_rsp_id <= w_gnt_ldr;
      // count only loader grants that made a waiting core wait longer
      if (boot_mode || !core_req || w_gnt_core) begin
        r_burst_cnt <= 4'h0;
      end else if (w_gnt_ldr && w_burst_open) begin
        r_burst_cnt <= r_burst_cnt + 4'h1;
      end
    end
  end

endmodule
